// File: rtl/morph_filter_kxk.sv
// KxK binary erosion/dilation/bypass over a raster mask stream, with frame
// framing, per-frame mode and an end-of-frame flush that drains the window.
module morph_filter_kxk #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int K        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pixel_in,
    input  logic       valid_in,
    input  logic       sof_in,
    input  logic [1:0] mode,
    output logic       in_ready,
    output logic       pixel_out,
    output logic       valid_out,
    output logic       eof_out
);

    localparam int R  = (K - 1) / 2;
    localparam int D  = R * H_ACTIVE + R;
    localparam int CW = $clog2(H_ACTIVE);
    localparam int RW = $clog2(V_ACTIVE);
    localparam int LW = $clog2(D + 1);

    localparam logic [CW-1:0] COL_LAST  = CW'(H_ACTIVE - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] LEAD_FULL = LW'(D);
    localparam logic [LW-1:0] FL_LAST   = LW'(D - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d, cur_col, nxt_col;
    logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d, cur_row;
    logic [LW-1:0] lead_q, lead_d, fl_q, fl_d;
    logic          pix_q, pix_d, vld_q, vld_d, eof_q, eof_d;
    logic          accept, sof_acc, step, new_pix, filt;
    logic [K-2:0]  lb_rd;
    logic [K-1:0]  new_col;
    logic [K-1:0]  win_q  [K];
    logic [K-1:0]  win_sh [K];

    assign in_ready = (state_q != FLUSH);
    assign accept   = valid_in && in_ready;
    assign sof_acc  = accept && sof_in;
    // One "step" advances the whole pipeline: an accepted pixel or a flush beat.
    assign step     = (state_q == FLUSH) || (state_q == STREAM && accept) || sof_acc;
    assign new_pix  = (state_q == FLUSH) ? 1'b0 : pixel_in;
    assign cur_col  = sof_acc ? '0 : in_col_q;
    assign cur_row  = sof_acc ? '0 : in_row_q;
    assign nxt_col  = (cur_col == COL_LAST) ? '0 : cur_col + CW'(1);

    assign new_col[K-1] = new_pix;

    // Line buffer gi holds row (current-1-gi); the read port prefetches the
    // next column so its registered output is ready at the following step.
    for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
        logic lb_mem_q [H_ACTIVE];
        logic lb_rd_q;
        logic lb_wr;
        if (gi == 0) begin : g_head
            assign lb_wr = new_pix;
        end else begin : g_tail
            assign lb_wr = lb_rd[gi-1];
        end
        always_ff @(posedge clk) begin
            if (step) begin
                lb_mem_q[cur_col] <= lb_wr;
                lb_rd_q           <= lb_mem_q[nxt_col];
            end
        end
        assign lb_rd[gi]          = lb_rd_q;
        assign new_col[K-2-gi]    = lb_rd_q;
    end

    // Window column j sits at dx = j-R; bit i of a column sits at dy = i-R.
    always_comb begin
        for (int j = 0; j < K - 1; j++) begin
            win_sh[j] = win_q[j+1];
        end
        win_sh[K-1] = new_col;
    end

    always_ff @(posedge clk) begin
        if (step) begin
            win_q <= win_sh;
        end
    end

    // Out-of-frame taps are skipped, which equals substituting the neutral value.
    always_comb begin
        logic all_ones;
        logic any_one;
        int   rr;
        int   cc;
        all_ones = 1'b1;
        any_one  = 1'b0;
        rr       = 0;
        cc       = 0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                rr = int'(out_row_q) + i - R;
                cc = int'(out_col_q) + j - R;
                if (rr >= 0 && rr < V_ACTIVE && cc >= 0 && cc < H_ACTIVE) begin
                    all_ones = all_ones & win_sh[j][i];
                    any_one  = any_one | win_sh[j][i];
                end
            end
        end
        case (mode_q)
            2'b01:   filt = all_ones;
            2'b10:   filt = any_one;
            default: filt = win_sh[R][R];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        lead_d    = lead_q;
        fl_d      = fl_q;
        pix_d     = 1'b0;
        vld_d     = 1'b0;
        eof_d     = 1'b0;
        if (step) begin
            in_col_d = nxt_col;
            if (cur_col == COL_LAST) begin
                in_row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                in_row_d = cur_row;
            end
            if (sof_acc) begin
                state_d   = STREAM;
                mode_d    = mode;
                lead_d    = LW'(1);
                out_col_d = '0;
                out_row_d = '0;
            end else begin
                if (lead_q != LEAD_FULL) begin
                    lead_d = lead_q + LW'(1);
                end else begin
                    vld_d     = 1'b1;
                    pix_d     = filt;
                    out_col_d = (out_col_q == COL_LAST) ? '0 : out_col_q + CW'(1);
                    if (out_col_q == COL_LAST) begin
                        out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
                    end
                end
                if (state_q == STREAM && cur_col == COL_LAST && cur_row == ROW_LAST) begin
                    state_d = FLUSH;
                    fl_d    = '0;
                end
                if (state_q == FLUSH) begin
                    if (fl_q == FL_LAST) begin
                        state_d = IDLE;
                        eof_d   = 1'b1;
                    end else begin
                        fl_d = fl_q + LW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            in_col_q  <= '0;
            in_row_q  <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
            lead_q    <= '0;
            fl_q      <= '0;
            pix_q     <= 1'b0;
            vld_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            lead_q    <= lead_d;
            fl_q      <= fl_d;
            pix_q     <= pix_d;
            vld_q     <= vld_d;
            eof_q     <= eof_d;
        end
    end

    assign pixel_out = pix_q;
    assign valid_out = vld_q;
    assign eof_out   = eof_q;

endmodule

// File: tb/tb_morph_filter_kxk.sv
// Directed bench for morph_filter_kxk: K=3 and K=5 instances share stimulus and
// are checked every output cycle against a frame-level reference model.
module tb_morph_filter_kxk;

    localparam int H = 8;
    localparam int V = 6;

    typedef struct packed {
        logic       pix;
        logic       eof;
        logic [7:0] idx;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       pixel_in;
    logic       valid_in;
    logic       sof_in;
    logic [1:0] mode;
    logic       rdy3, pout3, vout3, eof3;
    logic       rdy5, pout5, vout5, eof5;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        exp3[$];
    exp_t        exp5[$];
    logic [47:0] cap3, cap5;
    int          first_cyc3, first_cyc5;
    int          acc_cyc[48];

    morph_filter_kxk #(.H_ACTIVE(H), .V_ACTIVE(V), .K(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
        .sof_in(sof_in), .mode(mode), .in_ready(rdy3), .pixel_out(pout3),
        .valid_out(vout3), .eof_out(eof3));

    morph_filter_kxk #(.H_ACTIVE(H), .V_ACTIVE(V), .K(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
        .sof_in(sof_in), .mode(mode), .in_ready(rdy5), .pixel_out(pout5),
        .valid_out(vout5), .eof_out(eof5));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference: output at (r,c) from the full input frame with neutral padding.
    function automatic logic model_pix(input logic [47:0] f, input logic [1:0] md,
                                       input int k, input int idx);
        int   r, c, rad;
        logic acc;
        r   = idx / H;
        c   = idx % H;
        rad = (k - 1) / 2;
        if (md == 2'b01 || md == 2'b10) begin
            acc = (md == 2'b01);
            for (int dy = -rad; dy <= rad; dy++) begin
                for (int dx = -rad; dx <= rad; dx++) begin
                    if (r + dy >= 0 && r + dy < V && c + dx >= 0 && c + dx < H) begin
                        if (md == 2'b01) acc = acc & f[(r + dy) * H + c + dx];
                        else             acc = acc | f[(r + dy) * H + c + dx];
                    end
                end
            end
        end else begin
            acc = f[idx];
        end
        return acc;
    endfunction

    function automatic logic [47:0] model_frame(input logic [47:0] f, input logic [1:0] md,
                                                input int k);
        logic [47:0] o;
        o = '0;
        for (int m = 0; m < H * V; m++) o[m] = model_pix(f, md, k, m);
        return o;
    endfunction

    task automatic push_exp(input logic [47:0] f, input logic [1:0] md,
                            input int npix, input bit complete);
        for (int kk = 3; kk <= 5; kk += 2) begin
            int d, nout;
            d    = ((kk - 1) / 2) * H + (kk - 1) / 2;
            nout = complete ? H * V : npix - d;
            for (int m = 0; m < nout; m++) begin
                exp_t e;
                e.pix = model_pix(f, md, kk, m);
                e.eof = complete && (m == H * V - 1);
                e.idx = 8'(m);
                if (kk == 3) exp3.push_back(e);
                else         exp5.push_back(e);
            end
        end
    endtask

    // Single compare process: every output cycle of either DUT is checked.
    always @(negedge clk) begin
        exp_t e;
        if (vout3 || eof3) begin
            if (exp3.size() == 0) begin
                check("k3_unexpected_out", {vout3, eof3}, 2'b00);
            end else begin
                e = exp3.pop_front();
                check($sformatf("k3_out[%0d]", e.idx), {vout3, pout3, eof3}, {1'b1, e.pix, e.eof});
                cap3[e.idx] = pout3;
                if (e.idx == 0) first_cyc3 = cyc;
            end
        end
        if (vout5 || eof5) begin
            if (exp5.size() == 0) begin
                check("k5_unexpected_out", {vout5, eof5}, 2'b00);
            end else begin
                e = exp5.pop_front();
                check($sformatf("k5_out[%0d]", e.idx), {vout5, pout5, eof5}, {1'b1, e.pix, e.eof});
                cap5[e.idx] = pout5;
                if (e.idx == 0) first_cyc5 = cyc;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(rdy3 && rdy5) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", {rdy3, rdy5}, 2'b11);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp3.size() != 0 || exp5.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp3.size() + exp5.size()), 64'd0);
    endtask

    task automatic send_frame(input logic [47:0] f, input logic [1:0] md,
                              input logic [1:0] md_after, input bit gaps, input int npix);
        wait_idle();
        for (int idx = 0; idx < npix; idx++) begin
            if (gaps && $urandom_range(1) == 0) begin
                valid_in = 1'b0;
                pixel_in = ~f[idx];
                @(posedge clk); #1;
            end
            valid_in = 1'b1;
            pixel_in = f[idx];
            sof_in   = (idx == 0);
            mode     = (idx == 0) ? md : md_after;
            @(posedge clk); #1;
            acc_cyc[idx] = cyc;
        end
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] ones, single, rnd, sav3, sav5;
        logic [1:0]  md_list [4];
        ones   = 48'hFFFF_FFFF_FFFF;
        single = 48'h0000_0008_0000;
        rnd    = 48'h5AC3_3C96_0F5A;
        md_list[0] = 2'b10; md_list[1] = 2'b01; md_list[2] = 2'b00; md_list[3] = 2'b11;

        rst_n = 1'b0; pixel_in = 1'b0; valid_in = 1'b0; sof_in = 1'b0; mode = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {vout3, eof3, rdy3, vout5, eof5, rdy5}, 6'b001001);

        // Hand-computed pins for the reference model itself.
        check("pin_erode_ones_k3", model_frame(ones, 2'b01, 3), 48'hFFFF_FFFF_FFFF);
        check("pin_dilate_k3", model_frame(single, 2'b10, 3), 48'h0000_1C1C_1C00);
        check("pin_dilate_k5", model_frame(single, 2'b10, 5), 48'h003E_3E3E_3E3E);
        check("pin_erode_single", model_frame(single, 2'b01, 3), 48'h0);
        check("pin_bypass_single", model_frame(single, 2'b00, 3), 48'h0000_0008_0000);

        // Erode all-ones: latency, flush shape and eof position.
        @(posedge clk); #1;
        push_exp(ones, 2'b01, 48, 1'b1);
        send_frame(ones, 2'b01, 2'b01, 1'b0, 48);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("flush_beat%0d", i), {rdy3, vout3, eof3}, 3'b010);
        end
        @(negedge clk);
        check("flush_end", {rdy3, vout3, eof3}, 3'b111);
        wait_drain();
        check("k3_latency", 64'(first_cyc3), 64'(acc_cyc[9]));
        check("k5_latency", 64'(first_cyc5), 64'(acc_cyc[18]));
        check("k3_ones_frame", cap3, 48'hFFFF_FFFF_FFFF);
        check("k5_ones_frame", cap5, 48'hFFFF_FFFF_FFFF);

        // Single pixel under every mode, including the reserved one.
        for (int t = 0; t < 4; t++) begin
            push_exp(single, md_list[t], 48, 1'b1);
            send_frame(single, md_list[t], md_list[t], 1'b0, 48);
            wait_drain();
            check($sformatf("k3_single_md%0d", md_list[t]), cap3, model_frame(single, md_list[t], 3));
            check($sformatf("k5_single_md%0d", md_list[t]), cap5, model_frame(single, md_list[t], 5));
        end
        check("k5_dilate_literal", model_frame(single, 2'b10, 5) ^ 48'h003E_3E3E_3E3E, 48'h0);

        // Mode changes after sof are ignored; gaps do not alter the output.
        push_exp(rnd, 2'b01, 48, 1'b1);
        send_frame(rnd, 2'b01, 2'b10, 1'b0, 48);
        wait_drain();
        sav3 = cap3;
        sav5 = cap5;
        check("k3_mode_latch", sav3, model_frame(rnd, 2'b01, 3));
        push_exp(rnd, 2'b01, 48, 1'b1);
        send_frame(rnd, 2'b01, 2'b10, 1'b1, 48);
        wait_drain();
        check("k3_gaps_same", cap3, sav3);
        check("k5_gaps_same", cap5, sav5);

        // Abort at input index 20, then an all-zero erode frame.
        push_exp(rnd, 2'b10, 20, 1'b0);
        send_frame(rnd, 2'b10, 2'b10, 1'b0, 20);
        push_exp(48'h0, 2'b01, 48, 1'b1);
        send_frame(48'h0, 2'b01, 2'b01, 1'b0, 48);
        wait_drain();
        check("k3_abort_zero", cap3, 48'h0);
        check("k5_abort_zero", cap5, 48'h0);

        // Reset while input index 30 is presented.
        push_exp(rnd, 2'b01, 30, 1'b0);
        send_frame(rnd, 2'b01, 2'b01, 1'b0, 30);
        rst_n = 1'b0; valid_in = 1'b1; pixel_in = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; valid_in = 1'b0;
        @(negedge clk);
        check("reset_mid_frame", {vout3, eof3, rdy3, vout5, eof5, rdy5}, 6'b001001);
        repeat (60) @(negedge clk);
        check("reset_no_more", 64'(exp3.size() + exp5.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
